md_unit: RTL and testbench

Multiply/divide unit for the E stage of the five-stage pipeline. It takes the forwarded rs/rt operands of the instruction in E and runs mult/multu/div/divu over a fixed multi-cycle latency, or writes HI/LO directly for mthi/mtlo. It holds the HI/LO architectural registers and reports `busy`, which the hazard controller uses to stall any md-class instruction in D.

---
 rtl/md_unit_if.sv | 22 ++
 rtl/md_unit.sv | 125 ++++++++++++
 tb/tb_md_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E-stage datapath and the multiply/divide unit.
// The master drives the operation request; the slave returns HI/LO and status.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, rs_val, rt_val,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO architectural registers.
// Results are computed at start, held pending, then committed after a fixed latency.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // op[0] selects unsigned for both multiply and divide
  logic        isSigned;
  logic [63:0] mulA, mulB, product;
  logic        aNeg, bNeg;
  logic [31:0] aMag, bMag, qMag, rMag, quotient, remainder;

  assign isSigned = ~bus.op[0];
  assign mulA     = {{32{isSigned & bus.rs_val[31]}}, bus.rs_val};
  assign mulB     = {{32{isSigned & bus.rt_val[31]}}, bus.rt_val};
  assign product  = mulA * mulB;

  // Divide on magnitudes so INT_MIN / -1 falls out naturally as 0x80000000 rem 0
  assign aNeg      = isSigned & bus.rs_val[31];
  assign bNeg      = isSigned & bus.rt_val[31];
  assign aMag      = aNeg ? (32'd0 - bus.rs_val) : bus.rs_val;
  assign bMag      = bNeg ? (32'd0 - bus.rt_val) : bus.rt_val;
  assign qMag      = (bMag == 32'd0) ? 32'd0 : aMag / bMag;
  assign rMag      = (bMag == 32'd0) ? 32'd0 : aMag % bMag;
  assign quotient  = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
  assign remainder = aNeg ? (32'd0 - rMag) : rMag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (state_q == RUN) begin
      if (cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end else begin
        hi_d    = phi_q;
        lo_d    = plo_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    // The commit edge also accepts a new request, so hi_d/lo_d already hold the committed values
    if (bus.start && (state_q == IDLE || cnt_q == 5'd0)) begin
      case (bus.op)
        OP_MULT, OP_MULTU: begin
          phi_d   = product[63:32];
          plo_d   = product[31:0];
          cnt_d   = MULT_LOAD;
          state_d = RUN;
        end
        OP_DIV, OP_DIVU: begin
          if (bus.rt_val == 32'd0) begin
            phi_d = hi_d;
            plo_d = lo_d;
          end else begin
            phi_d = remainder;
            plo_d = quotient;
          end
          cnt_d   = DIV_LOAD;
          state_d = RUN;
        end
        OP_MTHI: hi_d = bus.rs_val;
        OP_MTLO: lo_d = bus.rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit against a plain-arithmetic HI/LO model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  logic [31:0] expHi;
  logic [31:0] expLo;

  md_unit_if mdIf();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Architectural effect of one accepted operation, straight from the arithmetic rules
  function automatic void modelOp(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint      a, b, sp;
    logic [63:0] up;
    case (op)
      3'd0: begin
        sp    = longint'($signed(rs)) * longint'($signed(rt));
        up    = 64'(sp);
        expHi = up[63:32];
        expLo = up[31:0];
      end
      3'd1: begin
        up    = 64'(rs) * 64'(rt);
        expHi = up[63:32];
        expLo = up[31:0];
      end
      3'd2: if (rt != 32'd0) begin
        a     = longint'($signed(rs));
        b     = longint'($signed(rt));
        expLo = 32'(a / b);
        expHi = 32'(a % b);
      end
      3'd3: if (rt != 32'd0) begin
        expLo = rs / rt;
        expHi = rs % rt;
      end
      3'd4: expHi = rs;
      3'd5: expLo = rs;
      default: ;
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int          n;
    int          lat;
    logic [31:0] oldHi;
    oldHi       = expHi;
    mdIf.start  = 1'b1;
    mdIf.op     = op;
    mdIf.rs_val = rs;
    mdIf.rt_val = rt;
    @(negedge clk);
    mdIf.start = 1'b0;
    modelOp(op, rs, rt);
    if (op <= 3'd3) begin
      lat = (op <= 3'd1) ? MC : DC;
      n = 0;
      while (mdIf.busy && n < 64) begin
        n++;
        if (n == 1) checkOutput("hiHeldDuringRun", mdIf.hi, oldHi);
        @(negedge clk);
      end
      checkOutput("busyLength", 32'(n), 32'(lat));
      checkOutput("donePulse", 32'(mdIf.done), 32'd1);
      checkOutput("hiCommit", mdIf.hi, expHi);
      checkOutput("loCommit", mdIf.lo, expLo);
      @(negedge clk);
      checkOutput("doneFall", 32'(mdIf.done), 32'd0);
    end else begin
      checkOutput("noBusy", 32'(mdIf.busy), 32'd0);
      checkOutput("noDone", 32'(mdIf.done), 32'd0);
      checkOutput("hiDirect", mdIf.hi, expHi);
      checkOutput("loDirect", mdIf.lo, expLo);
    end
  endtask

  initial begin
    logic        sawDone;
    logic [2:0]  rop;
    logic [31:0] rrs, rrt;
    compared    = 0;
    mismatched  = 0;
    expHi       = 32'd0;
    expLo       = 32'd0;
    reset       = 1'b1;
    mdIf.start  = 1'b0;
    mdIf.op     = 3'd0;
    mdIf.rs_val = 32'd0;
    mdIf.rt_val = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetHi", mdIf.hi, 32'd0);
    checkOutput("resetLo", mdIf.lo, 32'd0);
    checkOutput("resetBusy", 32'(mdIf.busy), 32'd0);
    checkOutput("resetDone", 32'(mdIf.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3'd1, 32'hFFFFFFFF, 32'h00000002);
    checkOutput("multuHi", mdIf.hi, 32'h00000001);
    checkOutput("multuLo", mdIf.lo, 32'hFFFFFFFE);
    applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5);
    checkOutput("multHi", mdIf.hi, 32'hFFFFFFFF);
    checkOutput("multLo", mdIf.lo, 32'hFFFFFFF1);
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    checkOutput("divHi", mdIf.hi, 32'hFFFFFFFF);
    checkOutput("divLo", mdIf.lo, 32'hFFFFFFFD);
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("divMinHi", mdIf.hi, 32'd0);
    checkOutput("divMinLo", mdIf.lo, 32'h80000000);
    applyStimulus(3'd4, 32'h00001234, 32'd0);
    applyStimulus(3'd5, 32'h00005678, 32'd0);
    applyStimulus(3'd3, 32'h00000010, 32'd0);
    checkOutput("divZeroHi", mdIf.hi, 32'h00001234);
    checkOutput("divZeroLo", mdIf.lo, 32'h00005678);

    // Ignored mthi mid-divide, then a multu accepted on the commit edge
    mdIf.start  = 1'b1;
    mdIf.op     = 3'd2;
    mdIf.rs_val = 32'hFFFFFFF9;
    mdIf.rt_val = 32'd2;
    @(negedge clk);
    modelOp(3'd2, 32'hFFFFFFF9, 32'd2);
    for (int n = 1; n <= DC; n++) begin
      checkOutput("b2bDivBusy", 32'(mdIf.busy), 32'd1);
      if (n == 3) begin
        mdIf.start  = 1'b1;
        mdIf.op     = 3'd4;
        mdIf.rs_val = 32'h0000DEAD;
      end else if (n == DC) begin
        mdIf.start  = 1'b1;
        mdIf.op     = 3'd1;
        mdIf.rs_val = 32'hFFFFFFFF;
        mdIf.rt_val = 32'd2;
      end else begin
        mdIf.start = 1'b0;
      end
      @(negedge clk);
    end
    mdIf.start = 1'b0;
    checkOutput("b2bDivDone", 32'(mdIf.done), 32'd1);
    checkOutput("b2bDivHi", mdIf.hi, expHi);
    checkOutput("b2bDivLo", mdIf.lo, expLo);
    checkOutput("b2bNotDead", 32'(mdIf.hi == 32'h0000DEAD), 32'd0);
    modelOp(3'd1, 32'hFFFFFFFF, 32'd2);
    for (int k = 0; k < MC; k++) begin
      checkOutput("b2bMultuBusy", 32'(mdIf.busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("b2bMultuIdle", 32'(mdIf.busy), 32'd0);
    checkOutput("b2bMultuDone", 32'(mdIf.done), 32'd1);
    checkOutput("b2bMultuHi", mdIf.hi, expHi);
    checkOutput("b2bMultuLo", mdIf.lo, expLo);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rrs = $urandom;
      case ($urandom_range(0, 7))
        0:       rrt = 32'd0;
        1:       rrt = 32'hFFFFFFFF;
        2:       rrt = 32'($urandom_range(1, 15));
        default: rrt = $urandom;
      endcase
      applyStimulus(rop, rrs, rrt);
    end

    // Asynchronous reset in the middle of a multiply discards the pending result
    applyStimulus(3'd4, 32'h0000AAAA, 32'd0);
    applyStimulus(3'd5, 32'h00005555, 32'd0);
    mdIf.start  = 1'b1;
    mdIf.op     = 3'd0;
    mdIf.rs_val = 32'd7;
    mdIf.rt_val = 32'd9;
    @(negedge clk);
    mdIf.start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstHi", mdIf.hi, 32'd0);
    checkOutput("asyncRstLo", mdIf.lo, 32'd0);
    checkOutput("asyncRstBusy", 32'(mdIf.busy), 32'd0);
    checkOutput("asyncRstDone", 32'(mdIf.done), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    sawDone = 1'b0;
    repeat (MC + 4) begin
      @(negedge clk);
      if (mdIf.done) sawDone = 1'b1;
    end
    checkOutput("noCommitAfterRst", 32'(sawDone), 32'd0);
    checkOutput("postRstHi", mdIf.hi, 32'd0);
    checkOutput("postRstLo", mdIf.lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
